// File: rtl/agc_loop_ctrl_if.sv
// -----------------------------------------------------------------------------
// agc_loop_ctrl_if
//   Bundle between the AGC loop controller and one AGC channel core.
//
//   Controller -> core : agc_tick_o      accumulator reset/start pulse
//                        agc_ce_o        accumulate enable
//                        agc_scale_o     scale value (17b unsigned)
//                        agc_offset_o    offset value (16b signed Q8.8)
//                        agc_scale_ce_o  scale load pulse
//                        agc_offset_ce_o offset load pulse
//                        agc_apply_o     apply pulse
//   Core -> controller : sq_accum_i      square accumulator (25b)
//                        gt_accum_i      greater-than count (21b)
//                        lt_accum_i      less-than count (21b)
//
//   Modports: master = loop controller, slave = AGC core.
// -----------------------------------------------------------------------------
interface agc_loop_ctrl_if;
    logic        agc_tick_o;
    logic        agc_ce_o;
    logic [16:0] agc_scale_o;
    logic [15:0] agc_offset_o;
    logic        agc_scale_ce_o;
    logic        agc_offset_ce_o;
    logic        agc_apply_o;
    logic [24:0] sq_accum_i;
    logic [20:0] gt_accum_i;
    logic [20:0] lt_accum_i;

    modport master (
        output agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o,
               agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
        input  sq_accum_i, gt_accum_i, lt_accum_i
    );

    modport slave (
        input  agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o,
               agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
        output sq_accum_i, gt_accum_i, lt_accum_i
    );
endinterface

// File: rtl/agc_loop_ctrl.sv
// -----------------------------------------------------------------------------
// agc_loop_ctrl
//   Closed-loop sequencer for one AGC channel core (aclk domain). Each
//   iteration: tick the core, hold accumulate enable for WINDOW_LEN cycles,
//   wait SETTLE_CYCLES, evaluate the accumulators, servo scale/offset with
//   saturating steps, pulse load then apply, and hold off HOLDOFF_CYCLES.
//
//   Ports:
//     aclk, aresetn      clock, asynchronous active-low reset
//     en_i               run continuously while high
//     single_i           run one iteration (accepted only when idle)
//     init_i             load scale/offset init values, clear lock (idle only)
//     scale_init_i       initial scale (17b unsigned)
//     offset_init_i      initial offset (16b signed Q8.8)
//     target_sq_i        target square-accumulator value
//     tol_sq_i           square tolerance half-width
//     deadband_i         allowed |gt-lt| before offset moves
//     scale_step_i       scale step magnitude
//     offset_step_i      offset step magnitude (Q8.8 LSB)
//     core               agc_loop_ctrl_if.master bundle to the AGC core
//     busy_o             high whenever not idle
//     iter_done_o        one-cycle pulse at the end of each iteration
//     locked_o           lock status
//     sat_cnt_o          saturation event count
//
//   Build option: AGC_LOOP_STATS_EN enables the sat_cnt_o counter;
//   without it sat_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module agc_loop_ctrl #(
    parameter int unsigned WINDOW_LEN     = 32768,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned LOCK_COUNT     = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                en_i,
    input  logic                single_i,
    input  logic                init_i,
    input  logic [16:0]         scale_init_i,
    input  logic [15:0]         offset_init_i,
    input  logic [24:0]         target_sq_i,
    input  logic [24:0]         tol_sq_i,
    input  logic [20:0]         deadband_i,
    input  logic [7:0]          scale_step_i,
    input  logic [7:0]          offset_step_i,
    agc_loop_ctrl_if.master     core,
    output logic                busy_o,
    output logic                iter_done_o,
    output logic                locked_o,
    output logic [15:0]         sat_cnt_o
);

    localparam int unsigned MAX_WS  = (WINDOW_LEN > SETTLE_CYCLES) ? WINDOW_LEN : SETTLE_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_WS > HOLDOFF_CYCLES) ? MAX_WS : HOLDOFF_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam int unsigned LW      = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TICK,
        ST_ACCUM,
        ST_SETTLE,
        ST_EVAL,
        ST_LOAD,
        ST_APPLY,
        ST_HOLDOFF
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            tick_q, ce_q, scale_ce_q, offset_ce_q, apply_q;
    logic            busy_q, done_q, locked_q, moved_q;
    logic [16:0]     scale_q;
    logic [15:0]     offset_q;
    logic [LW-1:0]   lock_cnt;

    // servo arithmetic
    logic [25:0]     hi_sum;
    logic [24:0]     sq_hi, sq_lo;
    logic            sq_high, sq_low;
    logic [17:0]     scale_up;
    logic            scale_dn_ovf, scale_up_ovf;
    logic [16:0]     scale_nx;
    logic [21:0]     lt_plus_db, gt_plus_db;
    logic            off_dec, off_inc;
    logic [16:0]     off_ext, off_dn, off_up;
    logic            off_dn_ovf, off_up_ovf;
    logic [15:0]     offset_nx;
    logic            moved;
    logic [LW-1:0]   lock_cnt_nx;

    // The accumulators are only consumed while in EVAL, where the FSM
    // registers the resulting scale/offset; the core holds them stable
    // through SETTLE, so no separate snapshot registers are kept.
    always_comb begin
        hi_sum  = {1'b0, target_sq_i} + {1'b0, tol_sq_i};
        sq_hi   = hi_sum[25] ? '1 : hi_sum[24:0];
        sq_lo   = (target_sq_i > tol_sq_i) ? (target_sq_i - tol_sq_i) : '0;
        sq_high = core.sq_accum_i > sq_hi;
        sq_low  = core.sq_accum_i < sq_lo;

        scale_up     = {1'b0, scale_q} + {10'd0, scale_step_i};
        scale_dn_ovf = scale_q < {9'd0, scale_step_i};
        scale_up_ovf = scale_up[17];
        scale_nx     = scale_q;
        if (sq_high)
            scale_nx = scale_dn_ovf ? '0 : (scale_q - {9'd0, scale_step_i});
        else if (sq_low)
            scale_nx = scale_up_ovf ? '1 : scale_up[16:0];

        // 22-bit sums so a large deadband cannot wrap the comparison
        lt_plus_db = {1'b0, core.lt_accum_i} + {1'b0, deadband_i};
        gt_plus_db = {1'b0, core.gt_accum_i} + {1'b0, deadband_i};
        off_dec    = {1'b0, core.gt_accum_i} > lt_plus_db;
        off_inc    = {1'b0, core.lt_accum_i} > gt_plus_db;

        // one guard bit: result leaves 16-bit range when bits 16 and 15 differ
        off_ext    = {offset_q[15], offset_q};
        off_dn     = off_ext - {9'd0, offset_step_i};
        off_up     = off_ext + {9'd0, offset_step_i};
        off_dn_ovf = off_dn[16] != off_dn[15];
        off_up_ovf = off_up[16] != off_up[15];
        offset_nx  = offset_q;
        if (off_dec)
            offset_nx = off_dn_ovf ? 16'h8000 : off_dn[15:0];
        else if (off_inc)
            offset_nx = off_up_ovf ? 16'h7FFF : off_up[15:0];

        moved = (scale_nx != scale_q) || (offset_nx != offset_q);

        if (moved_q)
            lock_cnt_nx = '0;
        else if (lock_cnt >= LOCK_MAX)
            lock_cnt_nx = lock_cnt;
        else
            lock_cnt_nx = lock_cnt + LW'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tick_q      <= 1'b0;
            ce_q        <= 1'b0;
            scale_ce_q  <= 1'b0;
            offset_ce_q <= 1'b0;
            apply_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            moved_q     <= 1'b0;
            scale_q     <= '0;
            offset_q    <= '0;
            lock_cnt    <= '0;
        end else begin
            tick_q      <= 1'b0;
            scale_ce_q  <= 1'b0;
            offset_ce_q <= 1'b0;
            apply_q     <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (init_i) begin
                        scale_q  <= scale_init_i;
                        offset_q <= offset_init_i;
                        lock_cnt <= '0;
                        locked_q <= 1'b0;
                    end else if (en_i || single_i) begin
                        state  <= ST_TICK;
                        tick_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_TICK: begin
                    state <= ST_ACCUM;
                    ce_q  <= 1'b1;
                    cnt   <= CW'(WINDOW_LEN - 1);
                end
                ST_ACCUM: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        ce_q  <= 1'b0;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0)
                        state <= ST_EVAL;
                    else
                        cnt <= cnt - CW'(1);
                end
                ST_EVAL: begin
                    scale_q     <= scale_nx;
                    offset_q    <= offset_nx;
                    moved_q     <= moved;
                    state       <= ST_LOAD;
                    scale_ce_q  <= 1'b1;
                    offset_ce_q <= 1'b1;
                end
                ST_LOAD: begin
                    state    <= ST_APPLY;
                    apply_q  <= 1'b1;
                    done_q   <= 1'b1;
                    lock_cnt <= lock_cnt_nx;
                    locked_q <= lock_cnt_nx >= LOCK_MAX;
                end
                ST_APPLY: begin
                    state <= ST_HOLDOFF;
                    cnt   <= CW'(HOLDOFF_CYCLES - 1);
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        if (en_i) begin
                            state  <= ST_TICK;
                            tick_q <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ce_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef AGC_LOOP_STATS_EN
    logic [15:0] sat_cnt_q;
    logic        sat_evt;

    assign sat_evt = (sq_high && scale_dn_ovf) || (sq_low && scale_up_ovf) ||
                     (off_dec && off_dn_ovf)   || (off_inc && off_up_ovf);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            sat_cnt_q <= '0;
        else if (state == ST_IDLE && init_i)
            sat_cnt_q <= '0;
        else if (state == ST_EVAL && sat_evt && sat_cnt_q != '1)
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    assign sat_cnt_o = '0;
`endif

    assign core.agc_tick_o      = tick_q;
    assign core.agc_ce_o        = ce_q;
    assign core.agc_scale_o     = scale_q;
    assign core.agc_offset_o    = offset_q;
    assign core.agc_scale_ce_o  = scale_ce_q;
    assign core.agc_offset_ce_o = offset_ce_q;
    assign core.agc_apply_o     = apply_q;
    assign busy_o               = busy_q;
    assign iter_done_o          = done_q;
    assign locked_o             = locked_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_agc_loop_ctrl
//   Self-checking bench for agc_loop_ctrl with WINDOW_LEN=64, SETTLE=8,
//   HOLDOFF=16. A scoreboard queue holds the expected scale/offset for each
//   iteration and is compared whenever the controller pulses its load strobe.
//   Servo cases come from a vector table; timing, lock, en drop and reset
//   are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_agc_loop_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        en_i, single_i, init_i;
    logic [16:0] scale_init_i;
    logic [15:0] offset_init_i;
    logic [24:0] target_sq_i, tol_sq_i;
    logic [20:0] deadband_i;
    logic [7:0]  scale_step_i, offset_step_i;
    logic        busy_o, iter_done_o, locked_o;
    logic [15:0] sat_cnt_o;

    agc_loop_ctrl_if bus ();

    agc_loop_ctrl #(
        .WINDOW_LEN    (64),
        .SETTLE_CYCLES (8),
        .HOLDOFF_CYCLES(16),
        .LOCK_COUNT    (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .en_i         (en_i),
        .single_i     (single_i),
        .init_i       (init_i),
        .scale_init_i (scale_init_i),
        .offset_init_i(offset_init_i),
        .target_sq_i  (target_sq_i),
        .tol_sq_i     (tol_sq_i),
        .deadband_i   (deadband_i),
        .scale_step_i (scale_step_i),
        .offset_step_i(offset_step_i),
        .core         (bus.master),
        .busy_o       (busy_o),
        .iter_done_o  (iter_done_o),
        .locked_o     (locked_o),
        .sat_cnt_o    (sat_cnt_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [16:0] scale_init;
        logic [15:0] offset_init;
        logic [24:0] target, tol, sq;
        logic [20:0] deadband, gt, lt;
        logic [7:0]  sstep, ostep;
        logic [16:0] exp_scale;
        logic [15:0] exp_offset;
        logic [15:0] exp_sat;
    } vec_t;

    typedef struct {
        logic [16:0] s;
        logic [15:0] o;
    } sb_t;

    vec_t vecs [9];
    sb_t  exp_q [$];
    sb_t  sb_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {7'd0, bus.agc_tick_o, bus.agc_ce_o, bus.agc_scale_o, bus.agc_offset_o,
                bus.agc_scale_ce_o, bus.agc_offset_ce_o, bus.agc_apply_o,
                busy_o, iter_done_o, locked_o, sat_cnt_o};
    endfunction

    // Scoreboard: every load strobe must match the oldest pending expectation.
    always @(negedge aclk) begin
        if (aresetn && bus.agc_scale_ce_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_load: got scale 0x%0h with no expectation queued",
                         bus.agc_scale_o);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_scale", bus.agc_scale_o, sb_e.s);
                check("sb_offset", bus.agc_offset_o, sb_e.o);
                check("sb_offset_ce", bus.agc_offset_ce_o, 1);
            end
        end
    end

    task automatic push_exp(input logic [16:0] s, input logic [15:0] o);
        sb_t e;
        e.s = s;
        e.o = o;
        exp_q.push_back(e);
    endtask

    task automatic set_loop(input logic [24:0] tgt, input logic [24:0] tol, input logic [24:0] sq,
                            input logic [20:0] db, input logic [20:0] gt, input logic [20:0] lt,
                            input logic [7:0] ss, input logic [7:0] os);
        target_sq_i    = tgt;
        tol_sq_i       = tol;
        bus.sq_accum_i = sq;
        deadband_i     = db;
        bus.gt_accum_i = gt;
        bus.lt_accum_i = lt;
        scale_step_i   = ss;
        offset_step_i  = os;
    endtask

    task automatic do_init(input logic [16:0] s, input logic [15:0] o);
        scale_init_i  = s;
        offset_init_i = o;
        init_i        = 1'b1;
        @(negedge aclk);
        init_i        = 1'b0;
    endtask

    task automatic pulse_single();
        single_i = 1'b1;
        @(negedge aclk);
        single_i = 1'b0;
    endtask

    task automatic wait_apply(input string name);
        int n = 0;
        while (bus.agc_apply_o !== 1'b1 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check(name, bus.agc_apply_o, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o !== 1'b0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check(name, busy_o, 0);
    endtask

    task automatic count_ticks(input int cycles, output int ticks);
        ticks = 0;
        repeat (cycles) begin
            @(negedge aclk);
            if (bus.agc_tick_o) ticks++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        logic [15:0] sat_exp;

        //                scale_init  offset_init target         tol        sq             deadband     gt           lt         ss     os     exp_scale  exp_off   sat
        vecs[0] = '{17'h01000, 16'h0000, 25'd1000,      25'd100,  25'd5000,      21'd10,      21'd0,       21'd0,     8'd16, 8'd16, 17'h00FF0, 16'h0000, 16'd0};
        vecs[1] = '{17'h1FFF8, 16'h8005, 25'd1000,      25'd100,  25'd0,         21'd10,      21'd1000,    21'd0,     8'd16, 8'd16, 17'h1FFFF, 16'h8000, 16'd1};
        vecs[2] = '{17'h00008, 16'h7FF8, 25'd1000,      25'd100,  25'd5000,      21'd10,      21'd0,       21'd1000,  8'd16, 8'd16, 17'h00000, 16'h7FFF, 16'd1};
        vecs[3] = '{17'h01234, 16'h0100, 25'd1000,      25'd100,  25'd1100,      21'd10,      21'd510,     21'd500,   8'd16, 8'd5,  17'h01234, 16'h0100, 16'd0};
        vecs[4] = '{17'h01234, 16'h0100, 25'd1000,      25'd100,  25'd900,       21'd10,      21'd500,     21'd511,   8'd16, 8'd5,  17'h01234, 16'h0105, 16'd0};
        vecs[5] = '{17'h01234, 16'h0100, 25'd1000,      25'd100,  25'd899,       21'd10,      21'd511,     21'd500,   8'd16, 8'd5,  17'h01244, 16'h00FB, 16'd0};
        vecs[6] = '{17'h00500, 16'hFF00, 25'h1FFFFFF,   25'h10,   25'h1FFFFFF,   21'h1FFFFF,  21'h1FFFFF,  21'h1FFFFF, 8'd16, 8'd16, 17'h00500, 16'hFF00, 16'd0};
        vecs[7] = '{17'h00777, 16'hFF00, 25'd50,        25'd100,  25'd0,         21'h1FFFF0,  21'h1FFFFF,  21'h000010, 8'd16, 8'd16, 17'h00777, 16'hFF00, 16'd0};
        vecs[8] = '{17'h00010, 16'h8100, 25'd1000,      25'd100,  25'd5000,      21'd0,       21'd100,     21'd0,     8'hFF, 8'hFF, 17'h00000, 16'h8001, 16'd1};

        aresetn  = 1'b0;
        en_i     = 1'b0;
        single_i = 1'b0;
        init_i   = 1'b0;
        scale_init_i  = '0;
        offset_init_i = '0;
        set_loop(25'd0, 25'd0, 25'd0, 21'd0, 21'd0, 21'd0, 8'd0, 8'd0);

        repeat (3) @(negedge aclk);
        check("reset_outputs", all_outs(), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_reset_busy", busy_o, 0);

        // ---- single-iteration timing, with init/single ignored while busy ----
        do_init(17'h01000, 16'h0000);
        check("init_scale", bus.agc_scale_o, 17'h01000);
        set_loop(25'd1000, 25'd100, 25'd5000, 21'd10, 21'd0, 21'd0, 8'd16, 8'd16);
        push_exp(17'h00FF0, 16'h0000);
        pulse_single();
        check("tick_cycle1", bus.agc_tick_o, 1);
        check("busy_cycle1", busy_o, 1);
        begin
            int cyc = 1, tick_n = 0, ce_n = 0, first_ce = 0, sce = 0, oce = 0;
            int ap = 0, idn = 0, idle_at = 0, glitch = 0;
            while (cyc < 200) begin
                if (bus.agc_tick_o) tick_n++;
                if (bus.agc_ce_o) ce_n++;
                if (bus.agc_ce_o && first_ce == 0) first_ce = cyc;
                if (bus.agc_scale_ce_o) sce = cyc;
                if (bus.agc_offset_ce_o) oce = cyc;
                if (bus.agc_apply_o) ap = cyc;
                if (iter_done_o) idn = cyc;
                if (cyc >= 2 && cyc <= 74 && bus.agc_scale_o != 17'h01000) glitch++;
                if (!busy_o) begin
                    idle_at = cyc;
                    break;
                end
                if (cyc == 20) begin
                    scale_init_i = 17'h00AAA;
                    init_i       = 1'b1;
                end
                if (cyc == 21) init_i = 1'b0;
                if (cyc == 80) single_i = 1'b1;
                if (cyc == 81) single_i = 1'b0;
                @(negedge aclk);
                cyc++;
            end
            check("tick_count", tick_n, 1);
            check("ce_len", ce_n, 64);
            check("ce_first_cycle", first_ce, 2);
            check("scale_ce_cycle", sce, 75);
            check("offset_ce_cycle", oce, 75);
            check("apply_cycle", ap, 76);
            check("iter_done_cycle", idn, 76);
            check("idle_cycle", idle_at, 93);
            check("scale_stable_in_window", glitch, 0);
        end
        count_ticks(20, ticks);
        check("single_ignored_when_busy", ticks, 0);

        // ---- servo/saturation vectors ----
        for (int i = 0; i < 9; i++) begin
            set_loop(vecs[i].target, vecs[i].tol, vecs[i].sq, vecs[i].deadband,
                     vecs[i].gt, vecs[i].lt, vecs[i].sstep, vecs[i].ostep);
            do_init(vecs[i].scale_init, vecs[i].offset_init);
            push_exp(vecs[i].exp_scale, vecs[i].exp_offset);
            pulse_single();
            wait_apply($sformatf("vec%0d_apply", i));
            wait_idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_locked", i), locked_o, 0);
`ifdef AGC_LOOP_STATS_EN
            sat_exp = vecs[i].exp_sat;
`else
            sat_exp = 16'd0;
`endif
            check($sformatf("vec%0d_sat_cnt", i), sat_cnt_o, sat_exp);
        end

        // ---- lock acquisition in continuous mode ----
        do_init(17'h01000, 16'h0000);
        set_loop(25'd1000, 25'd100, 25'd1000, 21'd10, 21'd500, 21'd500, 8'd16, 8'd16);
        en_i = 1'b1;
        for (int it = 1; it <= 4; it++) begin
            push_exp(17'h01000, 16'h0000);
            wait_apply($sformatf("lock_it%0d_apply", it));
            check($sformatf("lock_it%0d_locked", it), locked_o, (it >= 4) ? 1 : 0);
            @(negedge aclk);
        end

        // ---- lock loss ----
        bus.sq_accum_i = 25'd2000;
        push_exp(17'h00FF0, 16'h0000);
        wait_apply("lockloss_apply");
        check("lockloss_locked", locked_o, 0);
        @(negedge aclk);

        // ---- en_i dropped during ACCUM ----
        bus.sq_accum_i = 25'd1000;
        push_exp(17'h00FF0, 16'h0000);
        begin
            int n = 0;
            while (bus.agc_tick_o !== 1'b1 && n < 100) begin
                @(negedge aclk);
                n++;
            end
            check("endrop_tick", bus.agc_tick_o, 1);
        end
        repeat (5) @(negedge aclk);
        check("endrop_in_accum", bus.agc_ce_o, 1);
        en_i = 1'b0;
        wait_apply("endrop_apply");
        wait_idle("endrop_idle");
        count_ticks(150, ticks);
        check("endrop_no_more_ticks", ticks, 0);

        // ---- asynchronous reset during SETTLE ----
        do_init(17'h01000, 16'h0010);
        set_loop(25'd1000, 25'd100, 25'd5000, 21'd10, 21'd500, 21'd500, 8'd16, 8'd16);
        pulse_single();
        begin
            int n = 0;
            while (bus.agc_ce_o !== 1'b1 && n < 100) begin
                @(negedge aclk);
                n++;
            end
            while (bus.agc_ce_o !== 1'b0 && n < 200) begin
                @(negedge aclk);
                n++;
            end
        end
        check("rst_settle_busy", busy_o, 1);
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1 check("rst_async_outputs", all_outs(), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_idle", busy_o, 0);
        do_init(17'h01000, 16'h0010);
        check("rst_reinit_scale", bus.agc_scale_o, 17'h01000);
        push_exp(17'h00FF0, 16'h0010);
        pulse_single();
        check("rst_fresh_tick", bus.agc_tick_o, 1);
        wait_apply("rst_fresh_apply");
        wait_idle("rst_fresh_idle");

        repeat (4) @(negedge aclk);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
